// File: rtl/mnacidpro_sequencer_if.sv
// Host <-> sequencer signal bundle for the nucleic-acid purification chip.
// The host drives the command side; the sequencer drives status and valve lines.
interface mnacidpro_sequencer_if #(
    parameter int unsigned SIZE = 8
);
    logic            start;
    logic            abort;
    logic [SIZE-1:0] chan_mask;
    logic            busy;
    logic            done;
    logic            aborted;
    logic [2:0]      phase;
    logic            lysis_ctrl;
    logic            wash_ctrl;
    logic            elute_ctrl;
    logic            waste_ctrl;
    logic            bead_trap_ctrl;
    logic [SIZE-1:0] collect_ctrl;
    logic            flush_ctrl;
    logic [2:0]      pump;

    modport master (
        output start, abort, chan_mask,
        input  busy, done, aborted, phase, lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl,
               bead_trap_ctrl, collect_ctrl, flush_ctrl, pump
    );

    modport slave (
        input  start, abort, chan_mask,
        output busy, done, aborted, phase, lysis_ctrl, wash_ctrl, elute_ctrl, waste_ctrl,
               bead_trap_ctrl, collect_ctrl, flush_ctrl, pump
    );
endinterface

// File: rtl/mnacidpro_sequencer.sv
// Protocol sequencer: lysis -> wash -> per-channel elute -> flush -> done, with abort.
// Every output is registered; outputs are decoded from the next-state values.
module mnacidpro_sequencer #(
    parameter int unsigned SIZE     = 8,
    parameter int unsigned T_LYSIS  = 64,
    parameter int unsigned T_WASH   = 32,
    parameter int unsigned T_ELUTE  = 16,
    parameter int unsigned T_FLUSH  = 8,
    parameter int unsigned PUMP_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mnacidpro_sequencer_if.slave bus
);
    localparam int unsigned T_LW  = (T_LYSIS > T_WASH) ? T_LYSIS : T_WASH;
    localparam int unsigned T_EF  = (T_ELUTE > T_FLUSH) ? T_ELUTE : T_FLUSH;
    localparam int unsigned T_MAX = (T_LW > T_EF) ? T_LW : T_EF;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);
    localparam int unsigned CH_W  = $clog2(SIZE + 1);
    localparam int unsigned DIV_W = $clog2(PUMP_DIV + 1);

    localparam logic [CNT_W-1:0] LYSIS_LAST = CNT_W'(T_LYSIS - 1);
    localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(T_WASH - 1);
    localparam logic [CNT_W-1:0] ELUTE_LAST = CNT_W'(T_ELUTE - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(T_FLUSH - 1);
    localparam logic [CH_W-1:0]  CH_LAST    = CH_W'(SIZE - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(PUMP_DIV - 1);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLysis = 3'd1,
        StWash  = 3'd2,
        StElute = 3'd3,
        StFlush = 3'd4,
        StDone  = 3'd5
    } state_e;

    function automatic logic [2:0] pump_pattern(input logic [2:0] idx);
        logic [2:0] pat;
        pat = 3'b000;
        unique case (idx)
            3'd0:    pat = 3'b100;
            3'd1:    pat = 3'b110;
            3'd2:    pat = 3'b010;
            3'd3:    pat = 3'b011;
            3'd4:    pat = 3'b001;
            3'd5:    pat = 3'b101;
            default: pat = 3'b000;
        endcase
        return pat;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [SIZE-1:0]  mask_q, mask_d;
    logic [2:0]       pidx_q, pidx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             flag_q, flag_d;

    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            aborted_q, aborted_d;
    logic            lysis_q, lysis_d;
    logic            wash_q, wash_d;
    logic            elute_q, elute_d;
    logic            waste_q, waste_d;
    logic            bead_q, bead_d;
    logic [SIZE-1:0] collect_q, collect_d;
    logic            flush_q, flush_d;
    logic [2:0]      pump_q, pump_d;

    logic [SIZE-1:0] mask_sh_q, mask_sh_d;
    logic            ch_en_q, ch_en_d;
    logic            run_q, run_d;
    logic            abortable;

    // Next-state: phase sequencing, dwell/channel counters, pump step position.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        mask_d    = mask_q;
        pidx_d    = pidx_q;
        div_d     = div_q;
        flag_d    = flag_q;
        mask_sh_q = mask_q >> ch_q;
        ch_en_q   = mask_sh_q[0];
        run_q     = (state_q == StLysis) || (state_q == StWash) ||
                    ((state_q == StElute) && ch_en_q);
        abortable = (state_q == StLysis) || (state_q == StWash) || (state_q == StElute);

        if (run_q) begin
            if (div_q == DIV_LAST) begin
                div_d  = '0;
                pidx_d = (pidx_q == 3'd5) ? 3'd0 : pidx_q + 3'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    state_d = StLysis;
                    cnt_d   = '0;
                    ch_d    = '0;
                    mask_d  = bus.chan_mask;
                    pidx_d  = 3'd0;
                    div_d   = '0;
                    flag_d  = 1'b0;
                end
            end
            StLysis: begin
                if (cnt_q == LYSIS_LAST) begin
                    state_d = StWash;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWash: begin
                if (cnt_q == WASH_LAST) begin
                    state_d = StElute;
                    cnt_d   = '0;
                    ch_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StElute: begin
                // Masked channels are skipped in a single closed cycle.
                if (!ch_en_q || (cnt_q == ELUTE_LAST)) begin
                    cnt_d = '0;
                    if (ch_q == CH_LAST) begin
                        state_d = StFlush;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StFlush: begin
                if (cnt_q == FLUSH_LAST) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                flag_d  = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        if (bus.abort && abortable) begin
            state_d = StFlush;
            cnt_d   = '0;
            flag_d  = 1'b1;
        end
    end

    // Output decode from next state so every output leaves a flop.
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        lysis_d   = 1'b0;
        wash_d    = 1'b0;
        elute_d   = 1'b0;
        waste_d   = 1'b0;
        bead_d    = 1'b0;
        collect_d = '0;
        flush_d   = 1'b0;
        run_d     = 1'b0;
        mask_sh_d = mask_d >> ch_d;
        ch_en_d   = mask_sh_d[0];

        unique case (state_d)
            StLysis: begin
                busy_d  = 1'b1;
                lysis_d = 1'b1;
                bead_d  = 1'b1;
                waste_d = 1'b1;
                run_d   = 1'b1;
            end
            StWash: begin
                busy_d  = 1'b1;
                wash_d  = 1'b1;
                bead_d  = 1'b1;
                waste_d = 1'b1;
                run_d   = 1'b1;
            end
            StElute: begin
                busy_d = 1'b1;
                if (ch_en_d) begin
                    elute_d   = 1'b1;
                    bead_d    = 1'b1;
                    collect_d = SIZE'(1) << ch_d;
                    run_d     = 1'b1;
                end
            end
            StFlush: begin
                busy_d  = 1'b1;
                flush_d = 1'b1;
                waste_d = 1'b1;
            end
            StDone: begin
                done_d    = 1'b1;
                aborted_d = flag_d;
            end
            default: ;
        endcase

        pump_d = run_d ? pump_pattern(pidx_d) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ch_q      <= '0;
            mask_q    <= '0;
            pidx_q    <= 3'd0;
            div_q     <= '0;
            flag_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            lysis_q   <= 1'b0;
            wash_q    <= 1'b0;
            elute_q   <= 1'b0;
            waste_q   <= 1'b0;
            bead_q    <= 1'b0;
            collect_q <= '0;
            flush_q   <= 1'b0;
            pump_q    <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            mask_q    <= mask_d;
            pidx_q    <= pidx_d;
            div_q     <= div_d;
            flag_q    <= flag_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            lysis_q   <= lysis_d;
            wash_q    <= wash_d;
            elute_q   <= elute_d;
            waste_q   <= waste_d;
            bead_q    <= bead_d;
            collect_q <= collect_d;
            flush_q   <= flush_d;
            pump_q    <= pump_d;
        end
    end

    assign bus.phase          = state_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.aborted        = aborted_q;
    assign bus.lysis_ctrl     = lysis_q;
    assign bus.wash_ctrl      = wash_q;
    assign bus.elute_ctrl     = elute_q;
    assign bus.waste_ctrl     = waste_q;
    assign bus.bead_trap_ctrl = bead_q;
    assign bus.collect_ctrl   = collect_q;
    assign bus.flush_ctrl     = flush_q;
    assign bus.pump           = pump_q;
endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// Scoreboard bench: a plan-based protocol model predicts every output cycle,
// a monitor compares DUT outputs against the predicted queue on each falling edge.
module tb_mnacidpro_sequencer;
    localparam int unsigned SIZE     = 4;
    localparam int unsigned T_LYSIS  = 3;
    localparam int unsigned T_WASH   = 2;
    localparam int unsigned T_ELUTE  = 2;
    localparam int unsigned T_FLUSH  = 2;
    localparam int unsigned PUMP_DIV = 2;
    localparam int unsigned OW       = 15 + SIZE;

    typedef logic [OW-1:0] obs_t;
    typedef struct {
        int ph;
        bit en;
        int ch;
        bit ab;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mnacidpro_sequencer_if #(.SIZE(SIZE)) bus ();

    mnacidpro_sequencer #(
        .SIZE    (SIZE),
        .T_LYSIS (T_LYSIS),
        .T_WASH  (T_WASH),
        .T_ELUTE (T_ELUTE),
        .T_FLUSH (T_FLUSH),
        .PUMP_DIV(PUMP_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    obs_t       exp_q[$];
    step_t      plan[$];
    step_t      cur;
    int         runs;
    int         checks = 0;
    int         passes = 0;
    logic [2:0] pump_tab[6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    // Output image of one protocol step; pump position from total run cycles since start.
    function automatic obs_t expect_of(input step_t s, input int r);
        logic            run;
        logic            eluting;
        logic [SIZE-1:0] col;
        logic [2:0]      pmp;
        eluting = (s.ph == 3) && s.en;
        run     = (s.ph == 1) || (s.ph == 2) || eluting;
        col     = eluting ? (SIZE'(1) << s.ch) : '0;
        pmp     = run ? pump_tab[(r / PUMP_DIV) % 6] : 3'b000;
        return {3'(s.ph), (s.ph >= 1 && s.ph <= 4), (s.ph == 5), (s.ph == 5 && s.ab),
                (s.ph == 1), (s.ph == 2), eluting, (s.ph == 1 || s.ph == 2 || s.ph == 4),
                (s.ph == 1 || s.ph == 2 || eluting), col, (s.ph == 4), pmp};
    endfunction

    task automatic push_n(input int ph, input bit en, input int ch, input bit ab, input int n);
        step_t s;
        s.ph = ph;
        s.en = en;
        s.ch = ch;
        s.ab = ab;
        repeat (n) plan.push_back(s);
    endtask

    task automatic model_step();
        step_t           nxt;
        logic [SIZE-1:0] m;
        if (cur.ph == 1 || cur.ph == 2 || (cur.ph == 3 && cur.en)) runs++;
        if (rst) begin
            plan.delete();
            runs = 0;
        end else if (cur.ph == 0 && bus.start && !bus.abort) begin
            plan.delete();
            runs = 0;
            m    = bus.chan_mask;
            push_n(1, 0, 0, 0, T_LYSIS);
            push_n(2, 0, 0, 0, T_WASH);
            for (int c = 0; c < SIZE; c++) begin
                if (((m >> c) & SIZE'(1)) != 0) push_n(3, 1, c, 0, T_ELUTE);
                else push_n(3, 0, c, 0, 1);
            end
            push_n(4, 0, 0, 0, T_FLUSH);
            push_n(5, 0, 0, 0, 1);
        end else if (bus.abort && cur.ph >= 1 && cur.ph <= 3) begin
            plan.delete();
            push_n(4, 0, 0, 1, T_FLUSH);
            push_n(5, 0, 0, 1, 1);
        end
        if (!rst && plan.size() > 0) begin
            nxt = plan.pop_front();
        end else begin
            nxt.ph = 0;
            nxt.en = 0;
            nxt.ch = 0;
            nxt.ab = 0;
        end
        cur = nxt;
        exp_q.push_back(expect_of(nxt, runs));
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        obs_t want;
        obs_t got;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = {bus.phase, bus.busy, bus.done, bus.aborted, bus.lysis_ctrl, bus.wash_ctrl,
                    bus.elute_ctrl, bus.waste_ctrl, bus.bead_trap_ctrl, bus.collect_ctrl,
                    bus.flush_ctrl, bus.pump};
            checks++;
            if (got === want) passes++;
            else $display("FAIL outputs t=%0t got=%h want=%h", $time, got, want);
        end
    end

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act == want) passes++;
        else $display("FAIL %s got=%0d want=%0d", name, act, want);
    endtask

    task automatic drive(input bit s, input bit a, input logic [SIZE-1:0] m, input bit r);
        bus.start     = s;
        bus.abort     = a;
        bus.chan_mask = m;
        rst           = r;
        @(posedge clk);
        #1;
    endtask

    // Runs idle cycles (with start noise while busy) until done; lat = cycle index of done.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!bus.done && lat < 100) begin
            drive(($urandom % 3) == 0, 1'b0, SIZE'($urandom), 1'b0);
            lat++;
        end
    endtask

    initial begin
        int lat;
        cur.ph = 0;
        cur.en = 0;
        cur.ch = 0;
        cur.ab = 0;
        runs   = 0;
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 1);
        check("reset_phase", int'(bus.phase), 0);
        check("reset_busy", int'(bus.busy), 0);

        drive(1, 0, 4'b1111, 0);
        wait_done(1, lat);
        check("full_mask_done_cycle", lat, 16);
        check("full_mask_aborted", int'(bus.aborted), 0);
        drive(0, 0, '0, 0);
        check("full_mask_back_idle", int'(bus.phase), 0);

        drive(1, 0, 4'b0101, 0);
        wait_done(1, lat);
        check("mask0101_done_cycle", lat, 14);
        drive(0, 0, '0, 0);

        drive(1, 0, 4'b0000, 0);
        wait_done(1, lat);
        check("mask0000_done_cycle", lat, 12);
        drive(0, 0, '0, 0);

        drive(1, 0, 4'b1111, 0);
        drive(0, 0, '0, 0);
        drive(0, 0, '0, 0);
        drive(1, 0, 4'b0011, 0);
        drive(0, 1, '0, 0);
        check("abort_goes_flush", int'(bus.phase), 4);
        wait_done(5, lat);
        check("abort_done_cycle", lat, 7);
        check("abort_flag", int'(bus.aborted), 1);
        drive(0, 0, '0, 0);

        drive(1, 1, 4'b1111, 0);
        check("start_with_abort_ignored", int'(bus.phase), 0);
        drive(1, 0, 4'b1111, 0);
        repeat (6) drive(0, 0, '0, 0);
        check("in_elute_before_rst", int'(bus.phase), 3);
        drive(0, 0, '0, 1);
        check("rst_mid_run_phase", int'(bus.phase), 0);
        check("rst_mid_run_collect", int'(bus.collect_ctrl), 0);
        drive(0, 0, '0, 0);

        repeat (1500) begin
            drive(($urandom % 4) == 0, ($urandom % 12) == 0, SIZE'($urandom),
                  ($urandom % 200) == 0);
        end
        repeat (40) drive(0, 0, '0, 0);
        check("final_idle", int'(bus.phase), 0);
        check("scoreboard_depth", exp_q.size(), 1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
